move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler_if.sv | 37 +++
 rtl/move_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_move_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/move_scheduler_if.sv
// Bundle of the scheduler's control, map-port and status signals.
//   master : stimulus side (drives load/active/tick/keys/boss_en/map_wall)
//   slave  : move_scheduler (drives map address, positions, busy/done/caught)
interface move_scheduler_if;
    logic       load;
    logic       active;
    logic       tick;
    logic       dir_up;
    logic       dir_left;
    logic       dir_down;
    logic       dir_right;
    logic       boss_en;
    logic [8:0] map_x;
    logic [8:0] map_y;
    logic       map_wall;
    logic [8:0] player_x;
    logic [8:0] player_y;
    logic [8:0] boss_x;
    logic [8:0] boss_y;
    logic       busy;
    logic       done;
    logic       caught;

    modport master (
        output load, active, tick, dir_up, dir_left, dir_down, dir_right,
               boss_en, map_wall,
        input  map_x, map_y, player_x, player_y, boss_x, boss_y,
               busy, done, caught
    );

    modport slave (
        input  load, active, tick, dir_up, dir_left, dir_down, dir_right,
               boss_en, map_wall,
        output map_x, map_y, player_x, player_y, boss_x, boss_y,
               busy, done, caught
    );
endinterface

// File: rtl/move_scheduler.sv
// Per-tick movement scheduler for a player and a chasing boss that share a
// single wall-map lookup port. Each round checks the player's candidate
// square, optionally (every BOSS_DIV rounds) the boss's candidate square,
// then pulses done and updates the sticky caught flag.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : move_scheduler_if.slave
//          in : load, active, tick, dir_up/left/down/right, boss_en, map_wall
//          out: map_x/map_y, player_x/y, boss_x/y, busy, done, caught
//
// state | meaning
// IDLE  | waiting for a qualifying tick; map address shows the player
// P_REQ | player candidate presented on the map port
// P_CHK | map_wall sampled; player commits if the square is free
// B_REQ | boss candidate presented on the map port
// B_CHK | map_wall sampled; boss commits if the square is free
// DONE  | done pulse; caught evaluated on committed positions
module move_scheduler #(
    parameter int STEP     = 4,
    parameter int X_MAX    = 304,
    parameter int Y_MAX    = 224,
    parameter int P_X0     = 16,
    parameter int P_Y0     = 16,
    parameter int B_X0     = 288,
    parameter int B_Y0     = 208,
    parameter int HIT      = 12,
    parameter int BOSS_DIV = 2
) (
    input logic            clk,
    input logic            rst,
    move_scheduler_if.slave bus
);

    typedef enum logic [2:0] {IDLE, P_REQ, P_CHK, B_REQ, B_CHK, DONE} state_t;

    localparam logic [8:0] STEP9    = 9'(STEP);
    localparam logic [9:0] STEP10   = 10'(STEP);
    localparam logic [8:0] XLIM9    = 9'(X_MAX - STEP);
    localparam logic [8:0] YLIM9    = 9'(Y_MAX - STEP);
    localparam logic [8:0] PX0      = 9'(P_X0);
    localparam logic [8:0] PY0      = 9'(P_Y0);
    localparam logic [8:0] BX0      = 9'(B_X0);
    localparam logic [8:0] BY0      = 9'(B_Y0);
    localparam logic [9:0] HIT10    = 10'(HIT);
    localparam logic [7:0] DIV_LAST = 8'(BOSS_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q;
    logic [8:0] px_q, py_q, bx_q, by_q;
    logic [8:0] map_x_q, map_y_q;
    logic       done_q, caught_q;

    logic [8:0] p_cand_x, p_cand_y;
    logic [8:0] p_eff_x, p_eff_y;
    logic [8:0] b_cand_x, b_cand_y;
    logic signed [9:0] bdx, bdy, cdx, cdy;
    logic [9:0] badx, bady, cadx, cady;
    logic [8:0] bstep_x, bstep_y;
    logic       boss_turn, close;

    // Player candidate: one direction by priority, blocked at the field edge.
    always_comb begin
        p_cand_x = px_q;
        p_cand_y = py_q;
        if (bus.dir_up) begin
            if (py_q >= STEP9) p_cand_y = py_q - STEP9;
        end else if (bus.dir_down) begin
            if (py_q <= YLIM9) p_cand_y = py_q + STEP9;
        end else if (bus.dir_left) begin
            if (px_q >= STEP9) p_cand_x = px_q - STEP9;
        end else if (bus.dir_right) begin
            if (px_q <= XLIM9) p_cand_x = px_q + STEP9;
        end
    end

    // In P_CHK the player commit lands on the same edge that launches the
    // boss request, so the boss aims at the position the player ends up at.
    always_comb begin
        p_eff_x  = bus.map_wall ? px_q : map_x_q;
        p_eff_y  = bus.map_wall ? py_q : map_y_q;
        bdx      = $signed({1'b0, p_eff_x}) - $signed({1'b0, bx_q});
        bdy      = $signed({1'b0, p_eff_y}) - $signed({1'b0, by_q});
        badx     = bdx[9] ? $unsigned(-bdx) : $unsigned(bdx);
        bady     = bdy[9] ? $unsigned(-bdy) : $unsigned(bdy);
        // Clamp so the boss lands on, never past, the player coordinate.
        bstep_x  = (badx < STEP10) ? badx[8:0] : STEP9;
        bstep_y  = (bady < STEP10) ? bady[8:0] : STEP9;
        b_cand_x = bx_q;
        b_cand_y = by_q;
        if (badx >= bady && badx != 10'd0) begin
            b_cand_x = bdx[9] ? bx_q - bstep_x : bx_q + bstep_x;
        end else if (bady != 10'd0) begin
            b_cand_y = bdy[9] ? by_q - bstep_y : by_q + bstep_y;
        end
    end

    always_comb begin
        cdx   = $signed({1'b0, px_q}) - $signed({1'b0, bx_q});
        cdy   = $signed({1'b0, py_q}) - $signed({1'b0, by_q});
        cadx  = cdx[9] ? $unsigned(-cdx) : $unsigned(cdx);
        cady  = cdy[9] ? $unsigned(-cdy) : $unsigned(cdy);
        close = (cadx < HIT10) && (cady < HIT10);
    end

    assign boss_turn = bus.boss_en && (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.tick && bus.active) state_d = P_REQ;
            P_REQ:   state_d = P_CHK;
            P_CHK:   state_d = boss_turn ? B_REQ : DONE;
            B_REQ:   state_d = B_CHK;
            B_CHK:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.load) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            px_q     <= PX0;
            py_q     <= PY0;
            bx_q     <= BX0;
            by_q     <= BY0;
            map_x_q  <= PX0;
            map_y_q  <= PY0;
            done_q   <= 1'b0;
            caught_q <= 1'b0;
        end else if (bus.load) begin
            div_q    <= '0;
            px_q     <= PX0;
            py_q     <= PY0;
            bx_q     <= BX0;
            by_q     <= BY0;
            map_x_q  <= PX0;
            map_y_q  <= PY0;
            done_q   <= 1'b0;
            caught_q <= 1'b0;
        end else begin
            done_q <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (state_d == P_REQ) begin
                        map_x_q <= p_cand_x;
                        map_y_q <= p_cand_y;
                    end else begin
                        map_x_q <= px_q;
                        map_y_q <= py_q;
                    end
                end
                P_CHK: begin
                    if (!bus.map_wall) begin
                        px_q <= map_x_q;
                        py_q <= map_y_q;
                    end
                    div_q <= (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
                    if (boss_turn) begin
                        map_x_q <= b_cand_x;
                        map_y_q <= b_cand_y;
                    end else begin
                        map_x_q <= p_eff_x;
                        map_y_q <= p_eff_y;
                    end
                end
                B_CHK: begin
                    if (!bus.map_wall) begin
                        bx_q <= map_x_q;
                        by_q <= map_y_q;
                    end
                    map_x_q <= px_q;
                    map_y_q <= py_q;
                end
                DONE: begin
                    caught_q <= caught_q | close;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.map_x    = map_x_q;
    assign bus.map_y    = map_y_q;
    assign bus.player_x = px_q;
    assign bus.player_y = py_q;
    assign bus.boss_x   = bx_q;
    assign bus.boss_y   = by_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.caught   = caught_q;

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    move_scheduler_if bus ();

    move_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int px;
        int py;
        int bx;
        int by;
        int caught;
        int lat;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference state of the game, advanced independently of the DUT.
    int m_px = 16, m_py = 16, m_bx = 288, m_by = 208;
    int m_caught = 0, m_div = 0;

    logic [8:0] req_x, req_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Advance the reference state by one round and push the expected outcome.
    task automatic plan(input bit up, input bit down, input bit left, input bit right,
                        input bit be, input bit wall);
        int cx, cy, lat, dx, dy, ax, ay;
        exp_t e;
        cx  = m_px;
        cy  = m_py;
        lat = 3;
        if (up)         begin if (m_py - 4 >= 0)   cy = m_py - 4; end
        else if (down)  begin if (m_py + 4 <= 224) cy = m_py + 4; end
        else if (left)  begin if (m_px - 4 >= 0)   cx = m_px - 4; end
        else if (right) begin if (m_px + 4 <= 304) cx = m_px + 4; end
        if (!wall) begin
            m_px = cx;
            m_py = cy;
        end
        if (be && m_div == 1) begin
            lat = 5;
            dx = m_px - m_bx;
            dy = m_py - m_by;
            ax = iabs(dx);
            ay = iabs(dy);
            if (!wall && (ax != 0 || ay != 0)) begin
                if (ax >= ay) m_bx = m_bx + ((dx < 0) ? -((ax < 4) ? ax : 4) : ((ax < 4) ? ax : 4));
                else          m_by = m_by + ((dy < 0) ? -((ay < 4) ? ay : 4) : ((ay < 4) ? ay : 4));
            end
        end
        m_div = (m_div + 1) % 2;
        if (iabs(m_px - m_bx) < 12 && iabs(m_py - m_by) < 12) m_caught = 1;
        e.px = m_px; e.py = m_py; e.bx = m_bx; e.by = m_by;
        e.caught = m_caught; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic run_round(input string tag, input bit up, input bit down, input bit left,
                             input bit right, input bit be, input bit wall, input bit drop_act);
        int   cycles;
        exp_t e;
        bus.dir_up    = up;
        bus.dir_down  = down;
        bus.dir_left  = left;
        bus.dir_right = right;
        bus.boss_en   = be;
        bus.map_wall  = wall;
        plan(up, down, left, right, be, wall);
        @(posedge clk); #1;
        bus.tick = 1'b1;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        if (drop_act) bus.active = 1'b0;
        req_x  = bus.map_x;
        req_y  = bus.map_y;
        cycles = 1;
        while (bus.done !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(cycles), 32'(e.lat));
        chk({tag, "_player_x"}, 32'(bus.player_x), 32'(e.px));
        chk({tag, "_player_y"}, 32'(bus.player_y), 32'(e.py));
        chk({tag, "_boss_x"}, 32'(bus.boss_x), 32'(e.bx));
        chk({tag, "_boss_y"}, 32'(bus.boss_y), 32'(e.by));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_caught"}, 32'(bus.caught), 32'(e.caught));
        bus.active = 1'b1;
    endtask

    initial begin
        int seen_done;
        int cyc;
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.active    = 1'b0;
        bus.tick      = 1'b0;
        bus.dir_up    = 1'b0;
        bus.dir_left  = 1'b0;
        bus.dir_down  = 1'b0;
        bus.dir_right = 1'b0;
        bus.boss_en   = 1'b0;
        bus.map_wall  = 1'b0;

        #12;
        chk("rst_player_x", 32'(bus.player_x), 32'd16);
        chk("rst_player_y", 32'(bus.player_y), 32'd16);
        chk("rst_boss_x", 32'(bus.boss_x), 32'd288);
        chk("rst_boss_y", 32'(bus.boss_y), 32'd208);
        chk("rst_map_x", 32'(bus.map_x), 32'd16);
        chk("rst_map_y", 32'(bus.map_y), 32'd16);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_caught", 32'(bus.caught), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Tick while the stage is not running must be ignored.
        @(posedge clk); #1;
        bus.tick = 1'b1;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        chk("inactive_busy", 32'(bus.busy), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1;
        end
        chk("inactive_no_done", 32'(seen_done), 32'd0);
        bus.active = 1'b1;

        // First round; active drops mid-round and the round still completes.
        run_round("r1_right", 0, 0, 0, 1, 0, 0, 1);
        chk("r1_req_x", 32'(req_x), 32'd20);
        chk("r1_player_x_const", 32'(bus.player_x), 32'd20);

        run_round("r2_boss", 0, 0, 0, 1, 1, 0, 0);
        chk("r2_player_x_const", 32'(bus.player_x), 32'd24);
        chk("r2_boss_x_const", 32'(bus.boss_x), 32'd284);

        for (int i = 0; i < 6; i++) run_round("walk_left", 0, 0, 1, 0, 0, 0, 0);
        chk("left_at_zero", 32'(bus.player_x), 32'd0);
        run_round("left_edge", 0, 0, 1, 0, 0, 0, 0);
        chk("left_edge_req_x", 32'(req_x), 32'd0);

        run_round("wall_up", 1, 1, 0, 0, 0, 1, 0);
        chk("wall_req_y", 32'(req_y), 32'd12);
        chk("wall_player_y_const", 32'(bus.player_y), 32'd16);

        run_round("down", 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) run_round("walk_right", 0, 0, 0, 1, 0, 0, 0);
        chk("setup_x", 32'(bus.player_x), 32'd32);
        chk("setup_y", 32'(bus.player_y), 32'd20);

        // Player idles while the boss chases it down.
        for (int i = 0; i < 400 && m_caught == 0; i++) run_round("chase", 0, 0, 0, 0, 1, 0, 0);
        chk("chase_caught", 32'(bus.caught), 32'd1);
        for (int i = 0; i < 3; i++) run_round("sticky", 0, 0, 0, 0, 1, 0, 0);
        chk("sticky_caught", 32'(bus.caught), 32'd1);
        while (m_div != 1) run_round("align", 0, 0, 0, 0, 0, 0, 0);

        // Abort a boss round with load while the boss square is being checked.
        bus.boss_en   = 1'b1;
        bus.dir_right = 1'b1;
        @(posedge clk); #1;
        bus.tick = 1'b1;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        cyc = 1;
        while (cyc < 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_caught", 32'(bus.caught), 32'd0);
        chk("abort_player_x", 32'(bus.player_x), 32'd16);
        chk("abort_player_y", 32'(bus.player_y), 32'd16);
        chk("abort_boss_x", 32'(bus.boss_x), 32'd288);
        chk("abort_boss_y", 32'(bus.boss_y), 32'd208);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        m_px = 16; m_py = 16; m_bx = 288; m_by = 208;
        m_caught = 0; m_div = 0;

        // Divider was cleared by load: first round has no boss step.
        run_round("post_load_a", 0, 0, 0, 1, 1, 0, 0);
        run_round("post_load_b", 0, 0, 0, 1, 1, 0, 0);
        chk("post_load_boss_x", 32'(bus.boss_x), 32'd284);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
